// File: rtl/tx_link_ctrl.sv
// JESD204-style transmit link controller: walks IDLE -> CGS -> ILAS -> DATA and
// selects the character for each of the four octets carried per link-clock cycle.
module tx_link_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sync_n,
    input  logic        lmfc_synced,
    input  logic [3:0]  ms,
    input  logic [3:0]  me,
    output logic [11:0] oct_sel,
    output logic [1:0]  state,
    output logic [1:0]  mf_idx,
    output logic        link_up,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic [2:0] SEL_DATA = 3'd0;
    localparam logic [2:0] SEL_K    = 3'd1;
    localparam logic [2:0] SEL_R    = 3'd2;
    localparam logic [2:0] SEL_A    = 3'd3;
    localparam logic [2:0] SEL_Q    = 3'd4;
    localparam logic [2:0] SEL_ILA  = 3'd5;

    state_t     st_q;
    logic [1:0] mf_q;
    logic       q_pend_q;
    logic [1:0] low_cnt_q;
    logic       err_q;
    logic       sync_meta_q;
    logic       sync_q;

    logic [3:0]  ms_l;
    logic [3:0]  me_l;
    logic        cgs_exit;
    logic        walk;
    logic        ilas_done;
    logic        q_nx;
    logic [1:0]  mf_nx;
    logic [11:0] sel_c;
    logic        lmfc_loss;
    logic        resync;

    // Isolate the lowest set bit so malformed words with several markers still resolve.
    function automatic logic [3:0] lowest_bit(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    assign ms_l      = lowest_bit(ms);
    assign me_l      = lowest_bit(me);
    assign cgs_exit  = (st_q == ST_CGS) && en && sync_q && lmfc_synced && (ms != 4'd0);
    assign lmfc_loss = !lmfc_synced;
    assign resync    = !sync_q && (low_cnt_q == 2'd3);

    // Octets are scanned low to high; the multiframe index and the pending /Q/
    // ripple across the word so a marker anywhere in it is handled in one cycle.
    always_comb begin
        walk      = (st_q == ST_ILAS);
        ilas_done = 1'b0;
        mf_nx     = mf_q;
        q_nx      = (st_q == ST_ILAS) && q_pend_q;
        sel_c     = 12'd0;
        for (int i = 0; i < 4; i++) begin
            if (cgs_exit && ms_l[i]) begin
                walk = 1'b1;
            end
            if (ilas_done) begin
                sel_c[3*i +: 3] = SEL_DATA;
            end else if (walk) begin
                if (ms_l[i]) begin
                    sel_c[3*i +: 3] = SEL_R;
                    q_nx            = (mf_nx == 2'd1);
                end else if (me_l[i]) begin
                    sel_c[3*i +: 3] = SEL_A;
                    q_nx            = 1'b0;
                    if (mf_nx == 2'd3) begin
                        ilas_done = 1'b1;
                    end else begin
                        mf_nx = mf_nx + 2'd1;
                    end
                end else if (q_nx) begin
                    sel_c[3*i +: 3] = SEL_Q;
                    q_nx            = 1'b0;
                end else begin
                    sel_c[3*i +: 3] = SEL_ILA;
                end
            end else if (st_q == ST_DATA) begin
                sel_c[3*i +: 3] = SEL_DATA;
            end else begin
                sel_c[3*i +: 3] = SEL_K;
            end
        end
    end

    assign oct_sel = sel_c;
    assign state   = cgs_exit ? ST_ILAS : st_q;
    assign mf_idx  = mf_q;
    assign link_up = (st_q == ST_DATA);
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            mf_q        <= 2'd0;
            q_pend_q    <= 1'b0;
            low_cnt_q   <= 2'd0;
            err_q       <= 1'b0;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= sync_n;
            sync_q      <= sync_meta_q;
            if (!en) begin
                st_q      <= ST_IDLE;
                mf_q      <= 2'd0;
                q_pend_q  <= 1'b0;
                low_cnt_q <= 2'd0;
                err_q     <= 1'b0;
            end else begin
                case (st_q)
                    ST_IDLE: begin
                        st_q <= ST_CGS;
                    end
                    ST_CGS: begin
                        low_cnt_q <= 2'd0;
                        if (cgs_exit) begin
                            st_q     <= ST_ILAS;
                            mf_q     <= mf_nx;
                            q_pend_q <= q_nx;
                        end
                    end
                    ST_ILAS, ST_DATA: begin
                        if (lmfc_loss || resync) begin
                            st_q      <= ST_CGS;
                            mf_q      <= 2'd0;
                            q_pend_q  <= 1'b0;
                            low_cnt_q <= 2'd0;
                            if (lmfc_loss) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            low_cnt_q <= sync_q ? 2'd0 : low_cnt_q + 2'd1;
                            if (st_q == ST_ILAS) begin
                                if (ilas_done) begin
                                    st_q     <= ST_DATA;
                                    mf_q     <= 2'd0;
                                    q_pend_q <= 1'b0;
                                end else begin
                                    mf_q     <= mf_nx;
                                    q_pend_q <= q_nx;
                                end
                            end
                        end
                    end
                    default: begin
                        st_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Randomised bench for tx_link_ctrl: an octet-numbered reference model predicts
// every output word each cycle for several multiframe lengths and phases.
module tb_tx_link_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sync_n;
    logic        lmfc_synced;
    logic [3:0]  ms;
    logic [3:0]  me;
    logic [11:0] oct_sel;
    logic [1:0]  state;
    logic [1:0]  mf_idx;
    logic        link_up;
    logic        err;

    tx_link_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync_n      (sync_n),
        .lmfc_synced (lmfc_synced),
        .ms          (ms),
        .me          (me),
        .oct_sel     (oct_sel),
        .state       (state),
        .mf_idx      (mf_idx),
        .link_up     (link_up),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // LMFC stimulus: octet k of word wc sits at multiframe position (4*wc + ph + k) mod L.
    int L  = 16;
    int ph = 0;
    int wc = 0;

    // Reference model: link phase, ILAS octet number of octet 0 of the current word.
    int m_st;
    int n0;
    int low_run;
    bit err_m;
    bit s1, s2;
    int data_seen = 0;

    function automatic logic [3:0] lmfc_mark(input int pos_want);
        logic [3:0] v;
        v = 4'd0;
        for (int k = 0; k < 4; k++)
            if (((wc * 4 + ph + k) % L) == pos_want) v[k] = 1'b1;
        return v;
    endfunction

    // Character for ILAS octet number n (negative: before the first /R/).
    function automatic logic [2:0] ilas_code(input int n);
        int mf, pos;
        if (n < 0) return 3'd1;
        if (n >= 4 * L) return 3'd0;
        mf  = n / L;
        pos = n % L;
        if (pos == 0) return 3'd2;
        if (pos == L - 1) return 3'd3;
        if (mf == 1 && pos == 1) return 3'd4;
        return 3'd5;
    endfunction

    task automatic model_reset();
        m_st = 0; n0 = 0; low_run = 0; err_m = 0; s1 = 0; s2 = 0;
    endtask

    bit entry;
    int p;

    task automatic model_eval_check();
        logic [11:0] w;
        int exp_state, exp_mf;
        entry = (m_st == 1) && en && s2 && lmfc_synced && (ms != 4'd0);
        p = 0;
        for (int k = 3; k >= 0; k--) if (ms[k]) p = k;
        w = 12'd0;
        for (int k = 0; k < 4; k++) begin
            if (m_st == 2)      w[3*k +: 3] = ilas_code(n0 + k);
            else if (m_st == 3) w[3*k +: 3] = 3'd0;
            else if (entry)     w[3*k +: 3] = ilas_code(k - p);
            else                w[3*k +: 3] = 3'd1;
        end
        exp_state = entry ? 2 : m_st;
        exp_mf    = (m_st == 2) ? n0 / L : 0;
        exp_q.push_back(w);
        check("oct_sel", {20'd0, oct_sel}, {20'd0, exp_q.pop_front()});
        check("state", {30'd0, state}, exp_state);
        check("mf_idx", {30'd0, mf_idx}, exp_mf);
        check("link_up", {31'd0, link_up}, {31'd0, m_st == 3});
        check("err", {31'd0, err}, {31'd0, err_m});
        if (m_st == 3) data_seen++;
    endtask

    task automatic model_advance();
        bit sync_v, loss, rs;
        sync_v = s2;
        s2 = s1;
        s1 = sync_n;
        if (!en) begin
            m_st = 0; low_run = 0; err_m = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            low_run = 0;
            if (entry) begin
                m_st = 2;
                n0 = 4 - p;
            end
        end else begin
            loss = !lmfc_synced;
            rs   = !sync_v && (low_run + 1 >= 4);
            if (loss || rs) begin
                if (loss) err_m = 1;
                m_st = 1;
                low_run = 0;
            end else begin
                low_run = sync_v ? 0 : low_run + 1;
                if (m_st == 2) begin
                    if (n0 + 3 >= 4 * L - 1) m_st = 3;
                    else n0 = n0 + 4;
                end
            end
        end
    endtask

    task automatic drive_cycle(input bit en_v, input bit sync_v, input bit lmfc_v, input bit do_rst);
        @(negedge clk);
        en          = en_v;
        sync_n      = sync_v;
        lmfc_synced = lmfc_v;
        ms          = lmfc_mark(0);
        me          = lmfc_mark(L - 1);
        // Markers are don't-care in IDLE and DATA, so scramble them there.
        if ((m_st == 0 || m_st == 3) && $urandom_range(0, 1) == 1) begin
            ms = 4'($urandom_range(0, 15));
            me = 4'($urandom_range(0, 15));
        end
        #1;
        model_eval_check();
        if (do_rst) begin
            #1 rst_n = 1'b0;
            #1;
            check("rst_state", {30'd0, state}, 0);
            check("rst_oct_sel", {20'd0, oct_sel}, {20'd0, 12'o1111});
            check("rst_link_up", {31'd0, link_up}, 0);
            check("rst_err", {31'd0, err}, 0);
            check("rst_mf_idx", {30'd0, mf_idx}, 0);
            model_reset();
            entry = 1'b0;
            #1 rst_n = 1'b1;
        end
        model_advance();
        wc++;
    endtask

    initial begin
        int sync_left, lmfc_left, en_left;
        bit rst_done;
        rst_n = 1'b0; en = 1'b0; sync_n = 1'b0; lmfc_synced = 1'b1; ms = 4'd0; me = 4'd0;
        model_reset();
        #3;
        check("init_state", {30'd0, state}, 0);
        check("init_oct_sel", {20'd0, oct_sel}, {20'd0, 12'o1111});
        check("init_mf_idx", {30'd0, mf_idx}, 0);
        check("init_link_up", {31'd0, link_up}, 0);
        check("init_err", {31'd0, err}, 0);
        #1 rst_n = 1'b1;

        for (int ep = 0; ep < 8; ep++) begin
            drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
            if (ep < 2) begin
                L  = 16;
                ph = (ep == 0) ? 0 : 2;
            end else begin
                L  = $urandom_range(4, 20);
                ph = $urandom_range(0, L - 1);
            end
            drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
            for (int c = $urandom_range(2, 6); c > 0; c--) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
            sync_left = 0; lmfc_left = 0; en_left = 0; rst_done = 0;
            for (int c = 0; c < 300; c++) begin
                int r;
                bit do_rst;
                r = $urandom_range(0, 999);
                if (sync_left == 0 && lmfc_left == 0 && en_left == 0) begin
                    if (r < 6)       sync_left = $urandom_range(1, 5);
                    else if (r < 9)  lmfc_left = $urandom_range(1, 2);
                    else if (r < 11) en_left   = $urandom_range(1, 2);
                end
                do_rst = !rst_done && (m_st == 3) && ($urandom_range(0, 19) == 0);
                if (do_rst) rst_done = 1;
                drive_cycle(en_left == 0, sync_left == 0, lmfc_left == 0, do_rst);
                if (sync_left > 0) sync_left--;
                if (lmfc_left > 0) lmfc_left--;
                if (en_left > 0)   en_left--;
            end
        end
        check("reached_data", {31'd0, data_seen > 0}, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
